// File: rtl/player_anim_sequencer.sv
// player_anim_sequencer: per-frame player sprite animation state and ROM frame offset
module player_anim_sequencer #(
    parameter logic [20:0] FRAME_SIZE   = 21'd3264,
    parameter logic [20:0] LEFT_OFFSET  = 21'd50620,
    parameter logic [20:0] IDLE_BASE    = 21'd0,
    parameter logic [20:0] WALK_BASE    = 21'd3264,
    parameter logic [20:0] JUMP_BASE    = 21'd22848,
    parameter logic [20:0] SHOOT_BASE   = 21'd35904,
    parameter logic [2:0]  WALK_FRAMES  = 3'd6,
    parameter logic [2:0]  JUMP_FRAMES  = 3'd4,
    parameter logic [2:0]  SHOOT_FRAMES = 3'd2,
    parameter logic [2:0]  HOLD         = 3'd4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        moving,
    input  logic        jump,
    input  logic        fire,
    input  logic        playerDirection,
    output logic [20:0] frameOffset,
    output logic [1:0]  animState,
    output logic [2:0]  frameIndex,
    output logic        frameUpdate,
    output logic        jumpActive
);
    typedef enum logic [1:0] {IDLE, WALK, JUMP, SHOOT} stateT;

    stateT       state, nextState, exitState;
    logic [2:0]  idx, hold, nextIdx, nextHold;
    logic        dirLatched, nextDir, holdDone, seqEnd, stay;
    logic [20:0] nextBase, nextOffset;

    assign animState  = state;
    assign frameIndex = idx;

    // Next animation state/frame; every register holds its value unless frame_tick is high
    always_comb begin
        holdDone  = hold == HOLD - 3'd1;
        seqEnd    = holdDone && ((state == JUMP) ? idx == JUMP_FRAMES - 3'd1 : idx == SHOOT_FRAMES - 3'd1);
        exitState = moving ? WALK : IDLE;
        nextState = !frame_tick ? state :
                    (state == JUMP)  ? (seqEnd ? exitState : JUMP) :
                    (state == SHOOT) ? (jump ? JUMP : seqEnd ? exitState : SHOOT) :
                    jump ? JUMP : fire ? SHOOT : exitState;
        stay      = nextState == state && state != IDLE;
        nextIdx   = !frame_tick ? idx : !stay ? 3'd0 : !holdDone ? idx :
                    (state == WALK && idx == WALK_FRAMES - 3'd1) ? 3'd0 : idx + 3'd1;
        nextHold  = !frame_tick ? hold : (!stay || holdDone) ? 3'd0 : hold + 3'd1;
        nextDir   = frame_tick ? playerDirection : dirLatched;
        nextBase  = (nextState == WALK)  ? WALK_BASE :
                    (nextState == JUMP)  ? JUMP_BASE :
                    (nextState == SHOOT) ? SHOOT_BASE : IDLE_BASE;
        nextOffset = nextBase + 21'(nextIdx) * FRAME_SIZE + (nextDir ? LEFT_OFFSET : 21'd0);
    end

    // Register state and outputs together so the offset always matches the reported state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            idx         <= 3'd0;
            hold        <= 3'd0;
            dirLatched  <= 1'b0;
            frameOffset <= 21'd0;
            frameUpdate <= 1'b0;
            jumpActive  <= 1'b0;
        end else begin
            state       <= nextState;
            idx         <= nextIdx;
            hold        <= nextHold;
            dirLatched  <= nextDir;
            frameOffset <= nextOffset;
            frameUpdate <= frame_tick;
            jumpActive  <= nextState == JUMP;
        end
    end
endmodule

// File: tb/tb_player_anim_sequencer.sv
// tb_player_anim_sequencer: directed checks of the player animation sequencer
module tb_player_anim_sequencer;
    logic        Clk, Reset_n, frame_tick, moving, jump, fire, playerDirection;
    logic [20:0] frameOffset;
    logic [1:0]  animState;
    logic [2:0]  frameIndex;
    logic        frameUpdate, jumpActive;
    int          checks = 0;
    int          errors = 0;

    player_anim_sequencer dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .moving(moving),
        .jump(jump), .fire(fire), .playerDirection(playerDirection),
        .frameOffset(frameOffset), .animState(animState), .frameIndex(frameIndex),
        .frameUpdate(frameUpdate), .jumpActive(jumpActive)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkOut(input string tag, input int st, input int ix, input int off);
        chk({tag, " animState"}, int'(animState), st);
        chk({tag, " frameIndex"}, int'(frameIndex), ix);
        chk({tag, " frameOffset"}, int'(frameOffset), off);
        chk({tag, " jumpActive"}, int'(jumpActive), (st == 2) ? 1 : 0);
    endtask

    task automatic doTick();
        @(negedge Clk);
        frame_tick = 1'b1;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        chk("frameUpdate pulse", int'(frameUpdate), 1);
        @(posedge Clk);
        #1;
        chk("frameUpdate clear", int'(frameUpdate), 0);
    endtask

    initial begin
        Reset_n = 1'b1; frame_tick = 1'b0; moving = 1'b0; jump = 1'b0; fire = 1'b0; playerDirection = 1'b0;
        #3 Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chkOut("reset", 0, 0, 0);
        chk("reset frameUpdate", int'(frameUpdate), 0);
        @(negedge Clk) Reset_n = 1'b1;

        for (int t = 1; t <= 3; t++) begin
            doTick();
            chkOut("idle", 0, 0, 0);
        end

        moving = 1'b1;
        for (int t = 1; t <= 28; t++) begin
            doTick();
            chkOut($sformatf("walk t%0d", t), 1, ((t - 1) / 4) % 6, 3264 + (((t - 1) / 4) % 6) * 3264);
        end

        jump = 1'b1;
        doTick();
        chkOut("jump t1", 2, 0, 22848);
        jump = 1'b0;
        fire = 1'b1;
        for (int t = 2; t <= 16; t++) begin
            doTick();
            chkOut($sformatf("jump t%0d", t), 2, (t - 1) / 4, 22848 + ((t - 1) / 4) * 3264);
        end
        fire = 1'b0;
        doTick();
        chkOut("jump exit walk", 1, 0, 3264);

        moving = 1'b0;
        doTick();
        chkOut("back idle", 0, 0, 0);
        jump = 1'b1; fire = 1'b1;
        doTick();
        chkOut("jump+fire idle", 2, 0, 22848);
        jump = 1'b0; fire = 1'b0;
        doTick();
        doTick();
        chkOut("jump before reset", 2, 0, 22848);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chkOut("async reset", 0, 0, 0);
        chk("async reset frameUpdate", int'(frameUpdate), 0);
        @(negedge Clk) Reset_n = 1'b1;
        moving = 1'b1;
        doTick();
        chkOut("walk after reset", 1, 0, 3264);
        moving = 1'b0;
        doTick();
        chkOut("idle after reset", 0, 0, 0);

        fire = 1'b1;
        doTick();
        chkOut("shoot t1", 3, 0, 35904);
        fire = 1'b0;
        doTick();
        chkOut("shoot t2", 3, 0, 35904);
        jump = 1'b1;
        doTick();
        chkOut("shoot preempt", 2, 0, 22848);
        jump = 1'b0;
        for (int t = 2; t <= 16; t++) doTick();
        chkOut("jump t16", 2, 3, 32640);
        doTick();
        chkOut("jump exit idle", 0, 0, 0);

        fire = 1'b1;
        doTick();
        chkOut("shoot held t1", 3, 0, 35904);
        for (int t = 2; t <= 8; t++) begin
            doTick();
            chkOut($sformatf("shoot held t%0d", t), 3, (t - 1) / 4, 35904 + ((t - 1) / 4) * 3264);
        end
        doTick();
        chkOut("shoot exit", 0, 0, 0);
        doTick();
        chkOut("shoot reenter", 3, 0, 35904);
        fire = 1'b0;
        for (int t = 2; t <= 9; t++) doTick();
        chkOut("shoot done", 0, 0, 0);

        playerDirection = 1'b1;
        doTick();
        chkOut("face left", 0, 0, 50620);
        playerDirection = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chkOut("dir between ticks", 0, 0, 50620);
        doTick();
        chkOut("face right", 0, 0, 0);
        playerDirection = 1'b1; moving = 1'b1;
        doTick();
        chkOut("walk left", 1, 0, 53884);
        jump = 1'b1; fire = 1'b1;
        doTick();
        chkOut("all requests", 2, 0, 73468);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
